// File: rtl/mem_pkg.sv
// mem_pkg -- shared encodings for the data-memory controller.
//   size_e  : CPU access size encoding (byte / half / word / reserved).
//   state_e : controller FSM state encoding.
//   align_off : byte offset forced down to the natural alignment of a size.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    DONE  = 2'b11
  } state_e;

  // Half accesses ignore bit 0, word accesses ignore both offset bits.
  function automatic logic [1:0] align_off(input logic [1:0] off, input logic [1:0] sz);
    logic [1:0] res;
    res = off;
    if (sz == SZ_HALF) res = {off[1], 1'b0};
    else if (sz == SZ_WORD) res = 2'b00;
    return res;
  endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// byte_lane_merge -- combinational lane extraction / extension / merge.
// Ports:
//   old_word   in  32  word read from RAM (little-endian lanes, byte 0 = [7:0])
//   new_data   in  32  right-justified store data
//   size       in  2   access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   off        in  2   byte offset within the word, already size-aligned
//   sign_ext   in  1   1 = sign-extend loads, 0 = zero-extend
//   load_data  out 32  extracted and extended load result
//   merge_word out 32  old_word with the addressed lanes replaced by new_data
module byte_lane_merge
  import mem_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        sign_ext,
  output logic [31:0] load_data,
  output logic [31:0] merge_word
);

  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [31:0] lane_mask;
  logic [31:0] wshift;

  always_comb begin
    shamt     = {off, 3'b000};
    shifted   = old_word >> shamt;
    wshift    = new_data << shamt;
    load_data = old_word;
    lane_mask = 32'hFFFF_FFFF;
    case (size)
      SZ_BYTE: begin
        load_data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
        lane_mask = 32'h0000_00FF << shamt;
      end
      SZ_HALF: begin
        load_data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
        lane_mask = 32'h0000_FFFF << shamt;
      end
      default: begin
        load_data = old_word;
        lane_mask = 32'hFFFF_FFFF;
      end
    endcase
    merge_word = (old_word & ~lane_mask) | (wshift & lane_mask);
  end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl -- CPU-side data-memory controller for a single-port RAM with a
// shared bidirectional data bus. Sub-word stores are done read-modify-write.
// Optional feature: define MISALIGN_TRAP_EN to reject misaligned half/word
// accesses with err; otherwise misaligned addresses are forced down to the
// natural alignment of the access size.
// Ports:
//   CLK       in   1   clock, rising edge
//   Rst       in   1   asynchronous active-high reset
//   req       in   1   access request, sampled only while ready=1
//   we        in   1   1 = store, 0 = load
//   size      in   2   00 byte, 01 half, 10 word, 11 reserved (err)
//   sign_ext  in   1   load extension: 1 sign, 0 zero
//   addr      in   32  CPU byte address
//   wdata     in   32  right-justified store data
//   ready     out  1   idle, able to accept req
//   done      out  1   one-cycle completion pulse
//   rdata     out  32  load result, held until the next accepted load
//   err       out  1   one-cycle pulse for a rejected access
//   Addr      out  AW  RAM word address
//   R_W       out  1   RAM strobe: 1 write, 0 read
//   Data      io   32  RAM data bus, driven only while R_W=1
module dmem_ctrl
  import mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          AW        = 12
) (
  input  logic          CLK,
  input  logic          Rst,
  input  logic          req,
  input  logic          we,
  input  logic [1:0]    size,
  input  logic          sign_ext,
  input  logic [31:0]   addr,
  input  logic [31:0]   wdata,
  output logic          ready,
  output logic          done,
  output logic [31:0]   rdata,
  output logic          err,
  output logic [AW-1:0] Addr,
  output logic          R_W,
  inout  wire  [31:0]   Data
);

  state_e        state_q, state_d;
  logic          we_q, we_d;
  logic [1:0]    size_q, size_d;
  logic          sext_q, sext_d;
  logic [1:0]    off_q, off_d;
  logic          err_q, err_d;
  // Holds the CPU store data until READ, then the merged word to be written.
  logic [31:0]   wword_q, wword_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [AW-1:0] addr_q, addr_d;

  logic [31:0]   rel;
  logic          reject;
  logic [31:0]   load_data;
  logic [31:0]   merge_word;

  byte_lane_merge u_lane (
    .old_word   (Data),
    .new_data   (wword_q),
    .size       (size_q),
    .off        (off_q),
    .sign_ext   (sext_q),
    .load_data  (load_data),
    .merge_word (merge_word)
  );

  // Range check: an address below BASE_ADDR wraps to a huge offset, so a
  // single "upper bits zero" test covers both ends of the window.
  always_comb begin
    rel    = addr - BASE_ADDR;
    reject = ((rel >> (AW + 2)) != 32'd0) || (size == SZ_RSVD);
`ifdef MISALIGN_TRAP_EN
    if ((size == SZ_HALF && addr[0]) || (size == SZ_WORD && addr[1:0] != 2'b00))
      reject = 1'b1;
`endif
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    sext_d  = sext_q;
    off_d   = off_q;
    err_d   = err_q;
    wword_d = wword_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          size_d  = size;
          sext_d  = sign_ext;
          off_d   = align_off(rel[1:0], size);
          wword_d = wdata;
          if (reject) begin
            // Rejected: RAM address and data are left untouched.
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            addr_d  = rel[AW+1:2];
            state_d = (we && size == SZ_WORD) ? WRITE : READ;
          end
        end
      end
      READ: begin
        if (we_q) begin
          wword_d = merge_word;
          state_d = WRITE;
        end else begin
          rdata_d = load_data;
          state_d = DONE;
        end
      end
      WRITE:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      sext_q  <= 1'b0;
      off_q   <= 2'b00;
      err_q   <= 1'b0;
      wword_q <= 32'd0;
      rdata_q <= 32'd0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      off_q   <= off_d;
      err_q   <= err_d;
      wword_q <= wword_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
    end
  end

  // Strobe and bus enable decode straight from the state register, so reset
  // drops them without waiting for a clock edge.
  assign ready = (state_q == IDLE);
  assign done  = (state_q == DONE) && !err_q;
  assign err   = (state_q == DONE) && err_q;
  assign R_W   = (state_q == WRITE);
  assign Addr  = addr_q;
  assign rdata = rdata_q;
  assign Data  = R_W ? wword_q : 32'bz;

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address mapped to RAM word 0.
REQ-002 SHALL have parameter AW, default 12, meaning the RAM word-address width (4K words).
REQ-003 SHALL have port CLK  in  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port Rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req  in  1  CPU access request, sampled only when ready=1.
REQ-006 SHALL have port we  in  1  1 = store, 0 = load.
REQ-007 SHALL have port size  in  2  access size: 00 byte, 01 half, 10 word; 11 is reserved and raises err.
REQ-008 SHALL have port sign_ext  in  1  load extension: 1 = sign-extend, 0 = zero-extend.
REQ-009 SHALL have port addr  in  32  CPU byte address.
REQ-010 SHALL have port wdata  in  32  store data, right-justified.
REQ-011 SHALL have port ready  out  1  controller idle and able to accept req.
REQ-012 SHALL have port done  out  1  one-cycle completion pulse.
REQ-013 SHALL have port rdata  out  32  load result, valid while done=1 and held until the next accepted load.
REQ-014 SHALL have port err  out  1  one-cycle pulse for a rejected access; no RAM access is made.
REQ-015 SHALL have port Addr  out  AW  RAM word address.
REQ-016 SHALL have port R_W  out  1  RAM strobe: 1 = write, 0 = read.
REQ-017 SHALL have port Data  inout  32  RAM data bus; driven only while writing, otherwise 32'bz.

Function
REQ-018 SHALL use states IDLE, READ, WRITE, DONE; ready=1 only in IDLE.
REQ-019 SHALL form the word address as Addr = (addr-BASE_ADDR)[AW+1:2], with little-endian byte lanes (byte 0 = Data[7:0]).
REQ-020 SHALL, for a word store accepted at edge k, go IDLE->WRITE and drive R_W=1 plus Data=wdata during cycle k..k+1; the RAM commits at edge k+1; done=1 in the following cycle (DONE).
REQ-021 SHALL, for a load, go IDLE->READ with R_W=0, capture Data at edge k+1, and present extracted and extended rdata with done=1 in DONE.
REQ-022 SHALL perform a byte/half store as read-modify-write: READ (capture old word) -> WRITE (old word with target lanes replaced by wdata low bits) -> DONE; done arrives 3 cycles after acceptance.
REQ-023 SHALL always transition DONE->IDLE after one cycle; a req present in DONE is not accepted until IDLE.
REQ-024 SHALL ignore req while ready=0; CPU inputs are captured at acceptance, and later changes have no effect.
REQ-025 SHALL reject an address outside [BASE_ADDR, BASE_ADDR + 4*2^AW) or size=11: IDLE->DONE with err=1, done=0, and RAM untouched.
REQ-026 SHALL never drive Data while R_W=0, so there is no bus contention with RAM read output.

Reset
REQ-027 SHALL, while Rst=1, immediately force state=IDLE, ready=1, done=0, err=0, rdata=0, Addr=0, R_W=0, and Data released to z.
REQ-028 SHALL, on reset mid-operation, drop R_W asynchronously and commit no pending write; after Rst falls, the first accepted req behaves normally.

Configuration
REQ-029 SHALL, with MISALIGN_TRAP_EN defined, reject a half access with addr[0]=1 or a word access with addr[1:0]!=0 via err, exactly as in REQ-025.
REQ-030 SHALL, without MISALIGN_TRAP_EN, force misaligned addresses down to size alignment (half: addr[0] ignored; word: addr[1:0] ignored) and raise no err.

Structure
REQ-031 SHALL take the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the state encoding from shared package mem_pkg.
REQ-032 SHALL place lane extraction, extension and merge logic in combinational sub-module byte_lane_merge; the FSM, registers and tri-state control remain in dmem_ctrl.

Verification
REQ-033 SHALL check: word store 32'h0000_0077 @0x1028, then word load @0x1028 -> R_W=1 exactly one cycle, Addr=12'h40a, and load rdata=32'h0000_0077.
REQ-034 SHALL check: word 32'h0000_0078 @0x102C; byte store 8'hAB @0x102D; word load -> 32'h0000_AB78, and the neighbouring word 0x40a is unchanged.
REQ-035 SHALL check: word 32'h0000_80FF @0x1030; half load @0x1030 with sign_ext=1 -> 32'hFFFF_80FF; with sign_ext=0 -> 32'h0000_80FF.
REQ-036 SHALL check: load @0x4000 (out of range) -> err pulse, no R_W pulse, and Data stays z.
REQ-037 SHALL check: word store to 0x1029 -> err with MISALIGN_TRAP_EN; without it, the store writes Addr=12'h40a.
REQ-038 SHALL check: assert Rst during the WRITE state of a byte store -> R_W falls in the same cycle, the word keeps its old value, and ready=1 after reset.
